multi_ped_controller: RTL and testbench
=======================================

MULTI_PED_CONTROLLER -- requirements
Module: multi_ped_controller

Interface
REQ-001 Parameter NUM_PED, default 4, number of independent pedestrian crossing channels (1..16).
REQ-002 Parameter GREEN_CYCLES, default 8, full green duration in clk_main cycles (>=1).
REQ-003 Parameter GREEN_MIN, default 3, minimum green before early pre-emption (1..GREEN_CYCLES).
REQ-004 Parameter YELLOW_CYCLES, default 3, yellow duration (>=1).
REQ-005 Parameter RED_CYCLES, default 4, red duration when no walk is served (>=1).
REQ-006 Parameter WALK_CYCLES, default 6, walk duration (>=1).
REQ-007 Parameter CLEAR_CYCLES, default 2, all-red clearance after walk (>=1).
REQ-008 Parameter CNT_W, default 8, timer width; every *_CYCLES value SHALL be <= 2**CNT_W.
REQ-009 clk_main  input  1  single clock; all logic on its rising edge.
REQ-010 rst_main  input  1  synchronous, active-high reset.
REQ-011 button  input  NUM_PED  per-channel request, already synchronous to clk_main, level or pulse.
REQ-012 traffic_light  output  2  GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 never driven.
REQ-013 walk  output  NUM_PED  per-channel walk indication, registered.
REQ-014 pending  output  NUM_PED  per-channel latched-request flags, registered.
REQ-015 hold_red  output  1  high while in WALK or CLEAR.

Function
REQ-016 FSM states GREEN, YELLOW, RED, WALK, CLEAR; one down-counter loaded with N-1 on state entry; exit when it reads 0, so each timed state lasts exactly N cycles.
REQ-017 Transitions: GREEN->YELLOW after GREEN_CYCLES; YELLOW->RED after YELLOW_CYCLES; RED->WALK on the first RED cycle with |pending; RED->GREEN after RED_CYCLES if no pending arrived; WALK->CLEAR after WALK_CYCLES; CLEAR->GREEN after CLEAR_CYCLES.
REQ-018 traffic_light = RED in RED, WALK and CLEAR.
REQ-019 A rising edge of button[i] (sampled low then high) at cycle t SHALL set pending[i] at t+1; a held-high button SHALL register exactly once.
REQ-020 On the RED->WALK transition, walk SHALL be loaded with the pending snapshot and those pending bits cleared; walk bits stay constant through WALK and go low on entry to CLEAR.
REQ-021 A button edge in the snapshot cycle on a granted channel SHALL leave pending[i] set (set wins over clear), served next cycle of the phase.
REQ-022 Edges during WALK/CLEAR/GREEN/YELLOW SHALL only set pending; walk never changes mid-WALK.
REQ-023 walk SHALL never be nonzero unless traffic_light==RED.

Reset
REQ-024 With rst_main high at a clock edge: state=GREEN, counter=GREEN_CYCLES-1, traffic_light=2'b00, walk=0, pending=0, hold_red=0, edge-detect history=0.
REQ-025 Reset mid-WALK SHALL drop walk and pending on the next edge with no CLEAR phase.

Configuration
REQ-026 Macro PED_PREEMPT_EN: when defined, GREEN with |pending and at least GREEN_MIN cycles elapsed SHALL go to YELLOW next cycle; when undefined, GREEN always lasts GREEN_CYCLES and GREEN_MIN is unused.

Structure
REQ-027 Package multi_ped_pkg SHALL hold the state enum and the three light-encoding constants.
REQ-028 Sub-module ped_edge_latch (one per channel, generate loop) SHALL hold the edge detector and pending set/clear logic.

Verification (NUM_PED=4, defaults)
REQ-029 Reset, no buttons -> repeating 8 GREEN, 3 YELLOW, 4 RED cycles; walk=0 throughout.
REQ-030 button[2] pulse in GREEN cycle 1 -> pending=4'b0100 next cycle; at first RED cycle WALK entered, walk=4'b0100 for 6 cycles, 2 CLEAR, then GREEN; pending=0.
REQ-031 button=4'b1011 held high 20 cycles -> single registration each; walk=4'b1011 in one WALK phase, no repeat walk next cycle.
REQ-032 button[0] edge in snapshot cycle with pending[0]=1 -> walk[0]=1 and pending[0] stays 1; served again next cycle.
REQ-033 With PED_PREEMPT_EN: button[1] edge at GREEN cycle 0 -> YELLOW starts after GREEN cycle 3; without macro -> after cycle 8.
REQ-034 rst_main asserted at WALK cycle 3 -> next edge traffic_light=00, walk=0, pending=0, hold_red=0.

Source files
------------

// File: rtl/multi_ped_pkg.sv
// Shared types and light encodings for the multi-channel pedestrian crossing controller.
package multi_ped_pkg;

    typedef enum logic [2:0] {
        ST_GREEN  = 3'd0,
        ST_YELLOW = 3'd1,
        ST_RED    = 3'd2,
        ST_WALK   = 3'd3,
        ST_CLEAR  = 3'd4
    } ped_state_t;

    localparam logic [1:0] LIGHT_GREEN  = 2'b00;
    localparam logic [1:0] LIGHT_YELLOW = 2'b01;
    localparam logic [1:0] LIGHT_RED    = 2'b10;

endpackage

// File: rtl/ped_edge_latch.sv
// One pedestrian channel: rising-edge detector feeding a sticky request flag.
// A new edge in the same cycle as a grant keeps the flag set so the press is not lost.
module ped_edge_latch (
    input  logic clk_main,
    input  logic rst_main,
    input  logic button,
    input  logic clear,
    output logic pending
);

    logic button_prev_reg;
    logic pending_reg;
    logic pending_next;

    always_comb begin
        pending_next = (button & ~button_prev_reg) | (pending_reg & ~clear);
    end

    always_ff @(posedge clk_main) begin
        if (rst_main) begin
            button_prev_reg <= 1'b0;
            pending_reg     <= 1'b0;
        end else begin
            button_prev_reg <= button;
            pending_reg     <= pending_next;
        end
    end

    assign pending = pending_reg;

endmodule

// File: rtl/multi_ped_controller.sv
// Traffic light sequencer with NUM_PED pedestrian channels served together in one WALK phase.
// Optional early green termination on a pending request is enabled by the PED_PREEMPT_EN macro.
module multi_ped_controller
    import multi_ped_pkg::*;
#(
    parameter int NUM_PED       = 4,
    parameter int GREEN_CYCLES  = 8,
    parameter int GREEN_MIN     = 3,
    parameter int YELLOW_CYCLES = 3,
    parameter int RED_CYCLES    = 4,
    parameter int WALK_CYCLES   = 6,
    parameter int CLEAR_CYCLES  = 2,
    parameter int CNT_W         = 8
) (
    input  logic               clk_main,
    input  logic               rst_main,
    input  logic [NUM_PED-1:0] button,
    output logic [1:0]         traffic_light,
    output logic [NUM_PED-1:0] walk,
    output logic [NUM_PED-1:0] pending,
    output logic               hold_red
);

`ifdef PED_PREEMPT_EN
    localparam bit PREEMPT_ENABLE = 1'b1;
`else
    localparam bit PREEMPT_ENABLE = 1'b0;
`endif

    localparam logic [CNT_W-1:0] GREEN_LOAD  = CNT_W'(GREEN_CYCLES - 1);
    localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
    localparam logic [CNT_W-1:0] RED_LOAD    = CNT_W'(RED_CYCLES - 1);
    localparam logic [CNT_W-1:0] WALK_LOAD   = CNT_W'(WALK_CYCLES - 1);
    localparam logic [CNT_W-1:0] CLEAR_LOAD  = CNT_W'(CLEAR_CYCLES - 1);
    // Counter value at which GREEN_MIN green cycles (including the current one) have elapsed.
    localparam logic [CNT_W-1:0] PREEMPT_AT  = CNT_W'(GREEN_CYCLES - GREEN_MIN);

    ped_state_t         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next;
    logic [NUM_PED-1:0] walk_reg, walk_next;
    logic [NUM_PED-1:0] grant;
    logic               any_pending;
    logic               preempt_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PED; gi++) begin : g_chan
            ped_edge_latch u_latch (
                .clk_main (clk_main),
                .rst_main (rst_main),
                .button   (button[gi]),
                .clear    (grant[gi]),
                .pending  (pending[gi])
            );
        end
    endgenerate

    assign any_pending = |pending;
    assign preempt_hit = PREEMPT_ENABLE && any_pending && (cnt_reg <= PREEMPT_AT);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg - 1'b1;
        walk_next  = walk_reg;
        grant      = '0;
        case (state_reg)
            ST_GREEN: begin
                if (cnt_reg == '0 || preempt_hit) begin
                    state_next = ST_YELLOW;
                    cnt_next   = YELLOW_LOAD;
                end
            end
            ST_YELLOW: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RED;
                    cnt_next   = RED_LOAD;
                end
            end
            ST_RED: begin
                // Snapshot every latched request at once; the latches clear what was granted.
                if (any_pending) begin
                    state_next = ST_WALK;
                    cnt_next   = WALK_LOAD;
                    walk_next  = pending;
                    grant      = pending;
                end else if (cnt_reg == '0) begin
                    state_next = ST_GREEN;
                    cnt_next   = GREEN_LOAD;
                end
            end
            ST_WALK: begin
                if (cnt_reg == '0) begin
                    state_next = ST_CLEAR;
                    cnt_next   = CLEAR_LOAD;
                    walk_next  = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_reg == '0) begin
                    state_next = ST_GREEN;
                    cnt_next   = GREEN_LOAD;
                end
            end
            default: begin
                state_next = ST_GREEN;
                cnt_next   = GREEN_LOAD;
                walk_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_main) begin
        if (rst_main) begin
            state_reg <= ST_GREEN;
            cnt_reg   <= GREEN_LOAD;
            walk_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            walk_reg  <= walk_next;
        end
    end

    always_comb begin
        traffic_light = LIGHT_RED;
        case (state_reg)
            ST_GREEN:  traffic_light = LIGHT_GREEN;
            ST_YELLOW: traffic_light = LIGHT_YELLOW;
            default:   traffic_light = LIGHT_RED;
        endcase
    end

    assign walk     = walk_reg;
    assign hold_red = (state_reg == ST_WALK) || (state_reg == ST_CLEAR);

endmodule

// File: tb/tb_multi_ped_controller.sv
// Bench for multi_ped_controller: directed scenarios with literal expectations plus
// randomized button traffic compared every cycle against a phase/elapsed-time model.
module tb_multi_ped_controller;

    localparam int NP = 4;
    localparam int GC = 8;
    localparam int GM = 3;
    localparam int YC = 3;
    localparam int RC = 4;
    localparam int WC = 6;
    localparam int CC = 2;
`ifdef PED_PREEMPT_EN
    localparam bit PRE = 1'b1;
`else
    localparam bit PRE = 1'b0;
`endif
    // Green length when a request is already latched by green cycle 1.
    localparam int GREEN_P = PRE ? GM : GC;
    // Cycle (from reset release) at which a walk granted in the first RED starts.
    localparam int W0 = GREEN_P + YC + 1;

    localparam int P_G = 0, P_Y = 1, P_R = 2, P_W = 3, P_C = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NP-1:0] button = '0;
    logic [1:0]    traffic_light;
    logic [NP-1:0] walk;
    logic [NP-1:0] pending;
    logic          hold_red;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit model_en = 1'b0;

    int            m_phase = P_G;
    int            m_el = 0;
    logic [NP-1:0] m_pend = '0;
    logic [NP-1:0] m_walk = '0;
    logic [NP-1:0] m_prev = '0;

    multi_ped_controller #(
        .NUM_PED(NP), .GREEN_CYCLES(GC), .GREEN_MIN(GM), .YELLOW_CYCLES(YC),
        .RED_CYCLES(RC), .WALK_CYCLES(WC), .CLEAR_CYCLES(CC), .CNT_W(8)
    ) dut (
        .clk_main      (clk),
        .rst_main      (rst),
        .button        (button),
        .traffic_light (traffic_light),
        .walk          (walk),
        .pending       (pending),
        .hold_red      (hold_red)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Behavioural model: phase plus cycles elapsed in it, advanced by the phase rules.
    always @(posedge clk) begin : model
        logic [NP-1:0] edg;
        logic [NP-1:0] grant;
        if (rst) begin
            m_phase = P_G; m_el = 0; m_pend = '0; m_walk = '0; m_prev = '0;
        end else begin
            edg   = button & ~m_prev;
            grant = '0;
            m_el  = m_el + 1;
            case (m_phase)
                P_G: if (m_el == GC || (PRE && m_pend != 0 && m_el >= GM)) begin
                        m_phase = P_Y; m_el = 0;
                     end
                P_Y: if (m_el == YC) begin m_phase = P_R; m_el = 0; end
                P_R: if (m_pend != 0) begin
                        m_phase = P_W; m_el = 0; m_walk = m_pend; grant = m_pend;
                     end else if (m_el == RC) begin
                        m_phase = P_G; m_el = 0;
                     end
                P_W: if (m_el == WC) begin m_phase = P_C; m_el = 0; m_walk = '0; end
                default: if (m_el == CC) begin m_phase = P_G; m_el = 0; end
            endcase
            m_pend = edg | (m_pend & ~grant);
            m_prev = button;
        end
    end

    always @(negedge clk) begin : compare
        if (model_en) begin
            chk("model_light", 32'(traffic_light),
                32'((m_phase == P_G) ? 2'b00 : (m_phase == P_Y) ? 2'b01 : 2'b10));
            chk("model_walk", 32'(walk), 32'(m_walk));
            chk("model_pending", 32'(pending), 32'(m_pend));
            chk("model_hold_red", 32'(hold_red), 32'(m_phase >= P_W));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        button = '0;
        tick();
        tick();
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        do_reset();
        model_en = 1'b1;
        chk("reset_light", 32'(traffic_light), 32'(2'b00));
        chk("reset_walk", 32'(walk), 0);
        chk("reset_pending", 32'(pending), 0);
        chk("reset_hold_red", 32'(hold_red), 0);

        // Idle cycling: 8 green, 3 yellow, 4 red.
        for (int k = 0; k < 31; k++) begin
            run_to(k);
            chk("idle_light", 32'(traffic_light),
                32'(((k % 15) < 8) ? 2'b00 : ((k % 15) < 11) ? 2'b01 : 2'b10));
            chk("idle_walk", 32'(walk), 0);
        end
        $display("txn idle_cycle done cyc=%0d", cyc);

        // Single pulse on channel 2 during green cycle 1.
        do_reset();
        run_to(1); button = 4'b0100;
        tick(); button = '0;
        chk("pulse_pending", 32'(pending), 32'(4'b0100));
        run_to(PRE ? GM : GC);
        chk("green_end_light", 32'(traffic_light), 32'(2'b01));
        chk("green_last_light_prev", 32'(cyc), 32'(GREEN_P));
        run_to(W0 - 1);
        chk("snapshot_walk_low", 32'(walk), 0);
        tick();
        chk("walk_start", 32'(walk), 32'(4'b0100));
        chk("walk_hold_red", 32'(hold_red), 1);
        chk("walk_pending_cleared", 32'(pending), 0);
        run_to(W0 + WC - 1);
        chk("walk_last", 32'(walk), 32'(4'b0100));
        tick();
        chk("clear_walk", 32'(walk), 0);
        chk("clear_light", 32'(traffic_light), 32'(2'b10));
        run_to(W0 + WC + CC);
        chk("after_clear_light", 32'(traffic_light), 32'(2'b00));
        chk("after_clear_hold", 32'(hold_red), 0);
        $display("txn single_pulse done cyc=%0d", cyc);

        // Held buttons register once.
        do_reset();
        button = 4'b1011;
        run_to(W0);
        chk("held_walk", 32'(walk), 32'(4'b1011));
        chk("held_pending", 32'(pending), 0);
        run_to(20); button = '0;
        run_to(W0 + WC + CC + GC + YC + 1);
        chk("held_no_repeat_light", 32'(traffic_light), 32'(2'b10));
        chk("held_no_repeat_hold", 32'(hold_red), 0);
        chk("held_no_repeat_walk", 32'(walk), 0);
        $display("txn held_buttons done cyc=%0d", cyc);

        // Edge on a granted channel in the snapshot cycle survives the clear.
        do_reset();
        run_to(1); button = 4'b0001;
        tick(); button = '0;
        run_to(W0 - 1); button = 4'b0001;
        tick(); button = '0;
        chk("setwins_walk", 32'(walk), 32'(4'b0001));
        chk("setwins_pending", 32'(pending), 32'(4'b0001));
        run_to(2 * W0 + WC + CC - 1);
        chk("reserve_prev_walk", 32'(walk), 0);
        tick();
        chk("reserve_walk", 32'(walk), 32'(4'b0001));
        chk("reserve_pending", 32'(pending), 0);
        $display("txn set_wins done cyc=%0d", cyc);

        // Reset in the middle of WALK.
        do_reset();
        run_to(1); button = 4'b0010;
        tick(); button = '0;
        run_to(W0 + 1); button = 4'b1000;
        tick(); button = '0;
        run_to(W0 + 3);
        chk("prereset_pending", 32'(pending), 32'(4'b1000));
        rst = 1'b1;
        tick();
        chk("midwalk_rst_light", 32'(traffic_light), 0);
        chk("midwalk_rst_walk", 32'(walk), 0);
        chk("midwalk_rst_pending", 32'(pending), 0);
        chk("midwalk_rst_hold", 32'(hold_red), 0);
        rst = 1'b0;
        cyc = 0;
        $display("txn midwalk_reset done");

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            for (int b = 0; b < NP; b++)
                if ($urandom_range(0, 11) == 0) button[b] = ~button[b];
            rst = ($urandom_range(0, 399) == 0);
            tick();
        end
        rst = 1'b0;
        button = '0;
        tick();
        $display("txn random done cyc=%0d", cyc);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
